regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the dual-issue PE core pipeline.
- Provides NR combinational read ports and NW synchronous write ports, with defined write-write priority.
- Integrates a per-register busy scoreboard that issue logic uses for RAW hazard stalls.
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, minimum 2.
- AW, 5, address width; must equal log2(DEPTH).
- NR, 4, number of read ports.
- NW, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- we  in  NW  per-port write enable.
- waddr  in  NW*AW  write addresses; port i occupies bits [i*AW +: AW].
- wdata  in  NW*DW  write data, packed the same way.
- wclr  in  NW  per-port "clear busy bit of waddr" flag; qualified by we.
- raddr  in  NR*AW  read addresses.
- rdata  out  NR*DW  read data.
- rbusy  out  NR  busy bit of each raddr.
- iss_valid  in  1  mark iss_addr busy.
- iss_addr  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  DEPTH  full scoreboard snapshot.

Behaviour:
- Reset: on the clk edge with rst_n=0, all registers become 0 and all busy bits become 0.
  - rdata and rbusy read 0 from the next cycle.
  - Reset overrides every other input in that cycle.
- Write:
  - For each i with we[i]=1, registers[waddr_i] <= wdata_i at the clk edge.
  - Same-address conflict: the highest-index port wins for both data and wclr.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Read:
  - rdata_j is combinational, zero latency, and returns stored content.
  - If ZERO_REG=1, raddr=0 always returns 0 and rbusy=0.
- Scoreboard, next-state priority per register r:
  - Priority order: reset > flush > iss_valid&&iss_addr==r (set) > any we[i]&&wclr[i]&&waddr_i==r (clear) > hold.
  - Set beats clear, so a new producer issued in the same cycle as the old producer retiring leaves the bit at 1.
  - If ZERO_REG=1, busy[0] is never set.
- rbusy_j = busy_vec[raddr_j], read combinationally from the registered state.
  - With the bypass feature disabled, a same-cycle clear is not visible in rbusy.
- Out-of-range addresses cannot occur because DEPTH = 2^AW.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding is enabled.
  - If any we[i]=1 with waddr_i==raddr_j (and the address is not 0 when ZERO_REG=1), rdata_j = wdata of the highest such i.
  - rbusy_j is forced to 0 when that winning port also has wclr=1, unless iss_valid targets the same address in the same cycle.
- Undefined: rdata and rbusy show pre-edge state only; a written value is visible one cycle later.

Decomposition:
- Shared package header pe_defs.vh holds:
  - default DW, DEPTH and AW constants;
  - the packed-port slice macros;
  - the zero-register address constant.
- Single sub-module regfile_scoreboard: busy vector, set/clear/flush priority and busy_vec output.
  - Instantiated once.
  - Data storage, write arbitration and read muxing stay in regfile_mp.

Test Plan:
- Reset and zero register:
  - Stimulus: rst_n=0 for one edge, then write 0xDEADBEEF to r0 via port 0.
  - Response: all rdata=0 and busy_vec=0 after reset; reading r0 still returns 0.
- Write-write conflict:
  - Stimulus: port0 writes r5=0x11111111 and port1 writes r5=0x22222222 in the same cycle.
  - Response: next cycle r5 reads 0x22222222.
- Scoreboard set/clear:
  - Stimulus: iss_valid, iss_addr=7; two cycles later we[0]=1, waddr=7, wclr=1.
  - Response: rbusy for r7 is 1 for exactly two cycles, then 0.
- Simultaneous set and clear:
  - Stimulus: r9 busy; in one cycle iss_valid with iss_addr=9 and port1 we/wclr on r9.
  - Response: busy[9] remains 1 and r9 holds the new data.
- Flush:
  - Stimulus: set r3, r4, r12 busy, then assert flush together with iss_valid on r3.
  - Response: busy_vec=0 next cycle, since flush beats set.
- Bypass (REGFILE_BYPASS_EN defined):
  - Stimulus: write r6=0xCAFE0001 with wclr=1 and read r6 in the same cycle.
  - Response: rdata=0xCAFE0001 and rbusy=0 immediately.
  - Without the macro: the old value is read that cycle and the new value the next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and constants for the multi-port register file
package regfile_mp_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int NR_DEF    = 4;
    localparam int NW_DEF    = 2;

    // Register hardwired to zero when ZERO_REG is enabled
    localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/issue bundle between pipeline and register file
import regfile_mp_pkg::*;

interface regfile_mp_if #(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int NR    = NR_DEF,
    parameter int NW    = NW_DEF
);
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    wclr;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output we, waddr, wdata, wclr, raddr, iss_valid, iss_addr, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  we, waddr, wdata, wclr, raddr, iss_valid, iss_addr, flush,
        output rdata, rbusy, busy_vec
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - per-register busy bits with flush > set > clear priority
import regfile_mp_pkg::*;

module regfile_scoreboard #(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int NW       = NW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW-1:0]    wclr,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             clr;

    always_comb begin
        busy_nxt = busy;
        clr      = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            // Highest-index writer to r decides whether its busy bit clears
            clr = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (we[i] && waddr[i*AW +: AW] == AW'(r)) begin
                    clr = wclr[i];
                end
            end
            if (clr) begin
                busy_nxt[r] = 1'b0;
            end
            if (iss_valid && iss_addr == AW'(r)) begin
                busy_nxt[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[ZERO_ADDR] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NR-read/NW-write register file with busy scoreboard; optional REGFILE_BYPASS_EN forwarding
import regfile_mp_pkg::*;

module regfile_mp #(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = NR_DEF,
    parameter int NW       = NW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    logic [DW-1:0] mem [DEPTH];

    // Later ports are applied last, so the highest index wins a same-address conflict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i] && !(ZERO_REG != 0 && bus.waddr[i*AW +: AW] == AW'(ZERO_ADDR))) begin
                    mem[bus.waddr[i*AW +: AW]] <= bus.wdata[i*DW +: DW];
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .wclr      (bus.wclr),
        .iss_valid (bus.iss_valid),
        .iss_addr  (bus.iss_addr),
        .flush     (bus.flush),
        .busy_vec  (bus.busy_vec)
    );

    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] rd;
        logic          rb;
`ifdef REGFILE_BYPASS_EN
        logic          hit;
        logic          hclr;
`endif

        always_comb begin
            a  = bus.raddr[j*AW +: AW];
            rd = mem[a];
            rb = bus.busy_vec[a];
`ifdef REGFILE_BYPASS_EN
            hit  = 1'b0;
            hclr = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (bus.we[i] && bus.waddr[i*AW +: AW] == a) begin
                    hit  = 1'b1;
                    hclr = bus.wclr[i];
                    rd   = bus.wdata[i*DW +: DW];
                end
            end
            // A same-cycle reissue of this register keeps it busy despite the retiring write
            if (hit && hclr && !(bus.iss_valid && bus.iss_addr == a)) begin
                rb = 1'b0;
            end
`endif
            if (ZERO_REG != 0 && a == AW'(ZERO_ADDR)) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign bus.rdata[j*DW +: DW] = rd;
        assign bus.rbusy[j]          = rb;
    end

endmodule
